// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and FSM state encoding for the data-memory responder.
package dmem_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM; read data is registered on the access edge.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem_q[addr] <= wdata;
            rdata <= mem_q[addr];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready responder for the datapath data memory with programmable wait states.
// Request fields come straight from the inputs while IDLE and from the latch afterwards.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              lb,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic              resp_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              resp_err,
    output logic              busy
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, wr_q, lb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, dout_q, rdata;
    logic              idle, accept, access, sel_rd, sel_wr, err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, load_data;

    assign idle      = state_q == IDLE;
    assign accept    = idle && req_valid;
    assign sel_rd    = idle ? mem_rd : rd_q;
    assign sel_wr    = idle ? mem_wr : wr_q;
    assign sel_addr  = idle ? address : addr_q;
    assign sel_wdata = idle ? data_in : wdata_q;
    assign err       = sel_addr >= ADDR_W'(DEPTH) || sel_rd == sel_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
            cnt_d   = CNT_INIT;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    // The array is touched only on the edge entering RESP; reset suppresses it so a
    // discarded store can never land.
    assign access = state_d == RESP && state_q != RESP && !rst;

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .en    (access),
        .we    (access && sel_wr && !err),
        .addr  (sel_addr[AW-1:0]),
        .wdata (sel_wdata),
        .rdata (rdata)
    );

    assign load_data  = err ? '0 : lb_q ? {8'h00, rdata[7:0]} : rdata;
    assign resp_valid = state_q == RESP;
    assign resp_err   = resp_valid && err;
    assign data_out   = resp_valid && rd_q ? load_data : dout_q;
    assign req_ready  = idle;
    assign busy       = !idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q    <= mem_rd;
            wr_q    <= mem_wr;
            lb_q    <= lb;
            addr_q  <= address;
            wdata_q <= data_in;
        end
    end
endmodule
